// File: rtl/wb_arbiter_pkg.sv
// Shared definitions for the two-master Wishbone arbiter: bus widths,
// grant-state encoding and the round-robin winner selection.
package wb_arbiter_pkg;

    localparam int WB_ADDR_W = 24;
    localparam int RW        = 16;
    localparam int SEL_W     = 2;

    typedef enum logic [1:0] {
        ARB_S_IDLE = 2'd0,
        ARB_S_GNT0 = 2'd1,
        ARB_S_GNT1 = 2'd2
    } arb_state_e;

    // Index of the master to grant from idle; only meaningful when a cyc is high.
    // On a tie the master that did not own the bus last wins.
    function automatic logic rr_pick(input logic cyc0, input logic cyc1,
                                     input logic last_owner);
        return cyc1 && (!cyc0 || !last_owner);
    endfunction

endpackage

// File: rtl/wb_arb_timeout.sv
// Stalled-strobe watchdog for wb_arbiter: counts cycles of an unanswered
// strobe and flags expiry for one cycle when the count reaches TIMEOUT.
module wb_arb_timeout
    import wb_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic start_i,
    input  logic clear_i,
    output logic expired_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign expired_o = start_i && (cnt_q == CNT_W'(TIMEOUT));

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i || expired_o) begin
            cnt_d = '0;
        end else if (start_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: state registers take their next value with <= only; the
    // combinational next-state above uses = with a default first.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Two-master round-robin Wishbone arbiter granting whole cyc tenures.
// Optional stalled-strobe timeout is built when WB_ARB_TIMEOUT_EN is defined.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int ADDR_W  = WB_ADDR_W,
    parameter int DATA_W  = RW,
    parameter int TIMEOUT = 255
) (
    input  logic              i_clk,
    input  logic              i_rst_n,

    input  logic              m0_cyc,
    input  logic              m0_stb,
    input  logic              m0_we,
    input  logic              m0_4_burst,
    input  logic [ADDR_W-1:0] m0_adr,
    input  logic [DATA_W-1:0] m0_o_dat,
    input  logic [SEL_W-1:0]  m0_sel,
    output logic              m0_ack,
    output logic              m0_err,
    output logic [DATA_W-1:0] m0_i_dat,

    input  logic              m1_cyc,
    input  logic              m1_stb,
    input  logic              m1_we,
    input  logic              m1_4_burst,
    input  logic [ADDR_W-1:0] m1_adr,
    input  logic [DATA_W-1:0] m1_o_dat,
    input  logic [SEL_W-1:0]  m1_sel,
    output logic              m1_ack,
    output logic              m1_err,
    output logic [DATA_W-1:0] m1_i_dat,

    output logic              wb_cyc,
    output logic              wb_stb,
    output logic              wb_we,
    output logic              wb_4_burst,
    output logic [ADDR_W-1:0] wb_adr,
    output logic [DATA_W-1:0] wb_o_dat,
    output logic [SEL_W-1:0]  wb_sel,
    input  logic              wb_ack,
    input  logic              wb_err,
    input  logic [DATA_W-1:0] wb_i_dat,

    output logic              o_busy,
    output logic              o_owner
);

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("wb_arbiter: TIMEOUT must be at least 1");
    end

    arb_state_e state_q;
    logic       last_owner_q;
    logic       owner_q;
    logic [1:0] beat_q;

    logic gnt0;
    logic gnt1;
    logic busy;
    logic pick1;
    logic stb_raw;
    logic expired;
    logic bus_hit;
    logic own_ack;
    logic own_err;

    assign gnt0  = (state_q == ARB_S_GNT0);
    assign gnt1  = (state_q == ARB_S_GNT1);
    assign busy  = gnt0 | gnt1;
    assign pick1 = rr_pick(m0_cyc, m1_cyc, last_owner_q);

    // NOTE: every mux output is given a default before the branches, so no
    // latches are inferred; all of them decode from state_q, which resets
    // asynchronously, so the bus drops the moment i_rst_n falls.
    always_comb begin
        wb_cyc     = 1'b0;
        stb_raw    = 1'b0;
        wb_we      = 1'b0;
        wb_4_burst = 1'b0;
        wb_adr     = '0;
        wb_o_dat   = '0;
        wb_sel     = '0;
        if (gnt0) begin
            wb_cyc     = m0_cyc;
            stb_raw    = m0_cyc & m0_stb;
            wb_we      = m0_we;
            wb_4_burst = m0_4_burst;
            wb_adr     = m0_adr;
            wb_o_dat   = m0_o_dat;
            wb_sel     = m0_sel;
        end else if (gnt1) begin
            wb_cyc     = m1_cyc;
            stb_raw    = m1_cyc & m1_stb;
            wb_we      = m1_we;
            wb_4_burst = m1_4_burst;
            wb_adr     = m1_adr;
            wb_o_dat   = m1_o_dat;
            wb_sel     = m1_sel;
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    wb_arb_timeout #(
        .TIMEOUT   (TIMEOUT)
    ) u_timeout (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .start_i   (stb_raw & ~wb_ack & ~wb_err),
        .clear_i   (~busy | (stb_raw & (wb_ack | wb_err))),
        .expired_o (expired)
    );
`else
    assign expired = 1'b0;
`endif

    // An expiring strobe is withdrawn from the slave and answered with err.
    assign wb_stb  = stb_raw & ~expired;
    assign bus_hit = wb_cyc & wb_stb;
    assign own_ack = wb_ack & bus_hit;
    assign own_err = (wb_err & bus_hit) | expired;

    assign m0_ack   = gnt0 & own_ack;
    assign m0_err   = gnt0 & own_err;
    assign m0_i_dat = gnt0 ? wb_i_dat : '0;
    assign m1_ack   = gnt1 & own_ack;
    assign m1_err   = gnt1 & own_err;
    assign m1_i_dat = gnt1 ? wb_i_dat : '0;

    assign o_busy  = busy;
    assign o_owner = owner_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ARB_S_IDLE;
            last_owner_q <= 1'b1;
            owner_q      <= 1'b0;
            beat_q       <= '0;
        end else begin
            case (state_q)
                ARB_S_IDLE: begin
                    if (m0_cyc || m1_cyc) begin
                        owner_q <= pick1;
                        state_q <= pick1 ? ARB_S_GNT1 : ARB_S_GNT0;
                    end
                end
                ARB_S_GNT0, ARB_S_GNT1: begin
                    // wb_cyc mirrors the owner's cyc; its fall ends the tenure.
                    if (!wb_cyc) begin
                        state_q      <= ARB_S_IDLE;
                        last_owner_q <= owner_q;
                        beat_q       <= '0;
                    end else if (own_ack || own_err) begin
                        beat_q <= beat_q + 2'd1;
                    end
                end
                default: state_q <= ARB_S_IDLE;
            endcase
        end
    end

    a_beat_idle: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        (state_q == ARB_S_IDLE) |-> (beat_q == 2'd0));

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: a grant/route reference model predicts
// every cycle's outputs, a negedge monitor compares them against the DUT.
module tb_wb_arbiter;

    localparam int ADDR_W     = 24;
    localparam int DATA_W     = 16;
    localparam int TB_TIMEOUT = 8;
`ifdef WB_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    logic [1:0]        cyc = '0;
    logic [1:0]        stb = '0;
    logic [1:0]        we  = '0;
    logic [1:0]        bst = '0;
    logic [ADDR_W-1:0] adr  [2];
    logic [DATA_W-1:0] wdat [2];
    logic [1:0]        sel  [2];
    logic              wb_ack_s = 1'b0;
    logic              wb_err_s = 1'b0;
    logic [DATA_W-1:0] wb_rdat  = '0;

    logic              wb_cyc, wb_stb, wb_we, wb_4_burst;
    logic [ADDR_W-1:0] wb_adr;
    logic [DATA_W-1:0] wb_o_dat;
    logic [1:0]        wb_sel;
    logic              m0_ack, m0_err, m1_ack, m1_err;
    logic [DATA_W-1:0] m0_i_dat, m1_i_dat;
    logic              o_busy, o_owner;

    wb_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TB_TIMEOUT)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .m0_cyc(cyc[0]), .m0_stb(stb[0]), .m0_we(we[0]), .m0_4_burst(bst[0]),
        .m0_adr(adr[0]), .m0_o_dat(wdat[0]), .m0_sel(sel[0]),
        .m0_ack(m0_ack), .m0_err(m0_err), .m0_i_dat(m0_i_dat),
        .m1_cyc(cyc[1]), .m1_stb(stb[1]), .m1_we(we[1]), .m1_4_burst(bst[1]),
        .m1_adr(adr[1]), .m1_o_dat(wdat[1]), .m1_sel(sel[1]),
        .m1_ack(m1_ack), .m1_err(m1_err), .m1_i_dat(m1_i_dat),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_4_burst(wb_4_burst),
        .wb_adr(wb_adr), .wb_o_dat(wb_o_dat), .wb_sel(wb_sel),
        .wb_ack(wb_ack_s), .wb_err(wb_err_s), .wb_i_dat(wb_rdat),
        .o_busy(o_busy), .o_owner(o_owner)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic              cyc_o, stb_o, we_o, bst_o;
        logic [ADDR_W-1:0] adr_o;
        logic [DATA_W-1:0] wdat_o;
        logic [1:0]        sel_o;
        logic [1:0]        ack, err;
        logic [DATA_W-1:0] rdat0, rdat1;
        logic              busy, owner;
    } obs_t;

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: who holds the bus (-1 = nobody), who held it last,
    // the last granted index, and cycles the owner's strobe has gone unanswered.
    int owner   = -1;
    int last    = 1;
    int granted = 0;
    int wcnt    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
    endtask

    function automatic void model_reset();
        owner   = -1;
        last    = 1;
        granted = 0;
        wcnt    = 0;
    endfunction

    function automatic logic model_expired();
        logic raw;
        raw = cyc[owner] & stb[owner];
        return TO_EN && raw && !wb_ack_s && !wb_err_s && (wcnt == TB_TIMEOUT);
    endfunction

    function automatic obs_t model_outputs();
        obs_t e;
        logic hit, expd;
        e = '0;
        if (rst_n && owner >= 0) begin
            expd     = model_expired();
            e.cyc_o  = cyc[owner];
            e.stb_o  = cyc[owner] & stb[owner] & !expd;
            e.we_o   = we[owner];
            e.bst_o  = bst[owner];
            e.adr_o  = adr[owner];
            e.wdat_o = wdat[owner];
            e.sel_o  = sel[owner];
            hit      = e.cyc_o & e.stb_o;
            e.ack[owner] = wb_ack_s & hit;
            e.err[owner] = (wb_err_s & hit) | expd;
            if (owner == 0) e.rdat0 = wb_rdat;
            else            e.rdat1 = wb_rdat;
        end
        e.busy  = rst_n && (owner >= 0);
        e.owner = granted[0];
        return e;
    endfunction

    function automatic void model_step();
        logic raw, expd;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (owner < 0) begin
            wcnt = 0;
            if (cyc == 2'b11)  owner = 1 - last;
            else if (cyc[0])   owner = 0;
            else if (cyc[1])   owner = 1;
            if (owner >= 0) granted = owner;
        end else begin
            raw  = cyc[owner] & stb[owner];
            expd = model_expired();
            if (expd || (raw && (wb_ack_s || wb_err_s))) wcnt = 0;
            else if (raw)                                wcnt++;
            if (!cyc[owner]) begin
                last  = owner;
                owner = -1;
            end
        end
    endfunction

    // Called with this cycle's inputs in place: predict, then advance one edge.
    task automatic drive_cycle();
        exp_q.push_back(model_outputs());
        @(posedge clk);
        model_step();
        #1;
    endtask

    initial begin
        obs_t e, a;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                a = '0;
                a.cyc_o = wb_cyc; a.stb_o = wb_stb; a.we_o = wb_we; a.bst_o = wb_4_burst;
                a.adr_o = wb_adr; a.wdat_o = wb_o_dat; a.sel_o = wb_sel;
                a.ack = {m1_ack, m0_ack}; a.err = {m1_err, m0_err};
                a.rdat0 = m0_i_dat; a.rdat1 = m1_i_dat;
                a.busy = o_busy; a.owner = o_owner;
                check("sb_wb_ctrl", 64'({a.cyc_o, a.stb_o, a.we_o, a.bst_o, a.sel_o}),
                                    64'({e.cyc_o, e.stb_o, e.we_o, e.bst_o, e.sel_o}));
                check("sb_wb_adr",   64'(a.adr_o),  64'(e.adr_o));
                check("sb_wb_o_dat", 64'(a.wdat_o), 64'(e.wdat_o));
                check("sb_ack_err",  64'({a.ack, a.err}), 64'({e.ack, e.err}));
                check("sb_m0_i_dat", 64'(a.rdat0), 64'(e.rdat0));
                check("sb_m1_i_dat", 64'(a.rdat1), 64'(e.rdat1));
                check("sb_status",   64'({a.busy, a.owner}), 64'({e.busy, e.owner}));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: run exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int own;
        for (int m = 0; m < 2; m++) begin
            adr[m] = '0; wdat[m] = '0; sel[m] = '0;
        end
        @(posedge clk);
        #1;

        // Reset state, then a single m0 read from 0x000800.
        repeat (3) drive_cycle();
        rst_n = 1'b1;
        cyc[0] = 1'b1; stb[0] = 1'b1; adr[0] = 24'h000800; sel[0] = 2'b11;
        drive_cycle();
        wb_ack_s = 1'b1; wb_rdat = 16'hBEEF;
        #1;
        check("t1_wb_cyc",   64'(wb_cyc),   64'h1);
        check("t1_wb_adr",   64'(wb_adr),   64'h000800);
        check("t1_m0_ack",   64'(m0_ack),   64'h1);
        check("t1_m0_i_dat", 64'(m0_i_dat), 64'hBEEF);
        check("t1_m1_ack",   64'(m1_ack),   64'h0);
        drive_cycle();
        wb_ack_s = 1'b0; cyc[0] = 1'b0; stb[0] = 1'b0;
        repeat (2) drive_cycle();

        // Tie from reset: m0 burst of four beats, one idle cycle, then m1.
        rst_n = 1'b0;
        model_reset();
        drive_cycle();
        rst_n = 1'b1;
        cyc = 2'b11; stb = 2'b11; bst = 2'b11;
        adr[0] = 24'h100000; adr[1] = 24'h200000;
        drive_cycle();
        wb_ack_s = 1'b1;
        for (int b = 0; b < 4; b++) begin
            wb_rdat = DATA_W'(16'h1000 + b);
            #1;
            check("t2_m0_beat",  64'(m0_ack), 64'h1);
            check("t2_m1_quiet", 64'(m1_ack), 64'h0);
            drive_cycle();
        end
        wb_ack_s = 1'b0; cyc[0] = 1'b0; stb[0] = 1'b0; bst[0] = 1'b0;
        drive_cycle();
        #1;
        check("t2_idle_gap", 64'({wb_cyc, o_busy}), 64'h0);
        drive_cycle();
        #1;
        check("t2_m1_owner", 64'(o_owner), 64'h1);
        check("t2_m1_adr",   64'(wb_adr),  64'h200000);
        wb_ack_s = 1'b1;
        repeat (4) drive_cycle();
        wb_ack_s = 1'b0; cyc = '0; stb = '0; bst = '0;
        repeat (2) drive_cycle();

        // Both contend, each owner releases after one beat and re-raises at once.
        cyc = 2'b11; stb = 2'b11;
        for (int t = 0; t < 4; t++) begin
            n = 0;
            while (!o_busy && n < 8) begin
                drive_cycle();
                n++;
            end
            check("t3_granted", 64'(o_busy), 64'h1);
            check("t3_owner",   64'(o_owner), 64'(t % 2));
            own = int'(o_owner);
            wb_ack_s = 1'b1;
            drive_cycle();
            wb_ack_s = 1'b0; cyc[own] = 1'b0; stb[own] = 1'b0;
            drive_cycle();
            cyc[own] = 1'b1; stb[own] = 1'b1;
        end
        cyc = '0; stb = '0;
        repeat (3) drive_cycle();

        // m0 releases while m1 raises its request in the same cycle.
        cyc[0] = 1'b1; stb[0] = 1'b1; adr[0] = 24'h000123;
        drive_cycle();
        wb_ack_s = 1'b1;
        drive_cycle();
        wb_ack_s = 1'b0; cyc[0] = 1'b0; stb[0] = 1'b0;
        cyc[1] = 1'b1; stb[1] = 1'b1; bst[1] = 1'b1; adr[1] = 24'h00ABCD;
        drive_cycle();
        #1;
        check("t4_gap_cyc",  64'(wb_cyc), 64'h0);
        check("t4_gap_busy", 64'(o_busy), 64'h0);
        drive_cycle();
        #1;
        check("t4_m1_adr", 64'({wb_cyc, wb_adr}), 64'({1'b1, 24'h00ABCD}));

        // Reset pulsed asynchronously during beat 2 of that m1 burst.
        wb_ack_s = 1'b1;
        drive_cycle();
        wb_ack_s = 1'b0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("t5_async_cyc", 64'({wb_cyc, wb_stb}), 64'h0);
        check("t5_async_busy", 64'({o_busy, o_owner}), 64'h0);
        drive_cycle();
        rst_n = 1'b1;
        drive_cycle();
        #1;
        check("t5_regrant", 64'({o_busy, o_owner}), 64'h3);
        cyc[1] = 1'b0; stb[1] = 1'b0; bst[1] = 1'b0;
        repeat (2) drive_cycle();

`ifdef WB_ARB_TIMEOUT_EN
        // Slave never answers: err must arrive TIMEOUT cycles after the strobe.
        cyc[0] = 1'b1; stb[0] = 1'b1; adr[0] = 24'h000800;
        drive_cycle();
        n = 0;
        #1;
        while (!m0_err && n < 20) begin
            drive_cycle();
            n++;
            #1;
        end
        check("t6_timeout_delay", 64'(n), 64'(TB_TIMEOUT));
        check("t6_stb_forced_low", 64'(wb_stb), 64'h0);
        drive_cycle();
        cyc[0] = 1'b0; stb[0] = 1'b0;
        repeat (2) drive_cycle();
        #1;
        check("t6_released", 64'(o_busy), 64'h0);
`endif

        // Randomised traffic with occasional asynchronous resets.
        for (int c = 0; c < 1500; c++) begin
            for (int m = 0; m < 2; m++) begin
                if (cyc[m]) begin
                    if ($urandom_range(7) == 0) cyc[m] = 1'b0;
                end else if ($urandom_range(3) == 0) begin
                    cyc[m] = 1'b1;
                end
                stb[m]  = cyc[m] & ($urandom_range(3) != 0);
                we[m]   = 1'($urandom);
                bst[m]  = 1'($urandom);
                adr[m]  = ADDR_W'($urandom);
                wdat[m] = DATA_W'($urandom);
                sel[m]  = 2'($urandom);
            end
            wb_ack_s = ($urandom_range(1) == 0);
            wb_err_s = ($urandom_range(15) == 0);
            wb_rdat  = DATA_W'($urandom);
            if ($urandom_range(299) == 0) begin
                rst_n = 1'b0;
                model_reset();
            end else begin
                rst_n = 1'b1;
            end
            drive_cycle();
        end

        cyc = '0; stb = '0; wb_ack_s = 1'b0; wb_err_s = 1'b0; rst_n = 1'b1;
        repeat (2) drive_cycle();
        @(negedge clk);
        #1;
        check("scoreboard_drained", 64'(exp_q.size()), 64'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Two-master Wishbone arbiter sharing the single external bus port between the data cache (master 0) and the instruction cache (master 1). It grants whole bus tenures (single transfers or 4-beat bursts), rotates priority round-robin, and routes ack/err/data back only to the current owner. It sits between the cache controllers and the top-level Wishbone interface.

## Interface
- `ADDR_W`, default 24: Wishbone word-address width (`WB_ADDR_W`).
- `DATA_W`, default 16: data width (`RW`).
- `TIMEOUT`, default 255: cycles with `stb` high and no `ack`/`err` before a forced error (only with `WB_ARB_TIMEOUT_EN`).
- `i_clk`, input, 1: clock.
- `i_rst_n`, input, 1: asynchronous, active-low reset.
- `m0_cyc`, `m0_stb`, `m0_we`, `m0_4_burst`, inputs, 1 each: master 0 request signals. Same set for `m1_*`.
- `m0_adr`, input, ADDR_W; `m0_o_dat`, input, DATA_W; `m0_sel`, input, 2: master 0 address, write data, byte select. Same for `m1_*`.
- `m0_ack`, `m0_err`, outputs, 1; `m0_i_dat`, output, DATA_W: master 0 responses. Same for `m1_*`.
- `wb_cyc`, `wb_stb`, `wb_we`, `wb_4_burst`, outputs, 1; `wb_adr`, output, ADDR_W; `wb_o_dat`, output, DATA_W; `wb_sel`, output, 2: shared bus.
- `wb_ack`, `wb_err`, inputs, 1; `wb_i_dat`, input, DATA_W: shared bus responses.
- `o_busy`, output, 1: a grant is active.
- `o_owner`, output, 1: index of the current or last owner.

## Operation
- State register: `IDLE`, `GNT0`, `GNT1`. `o_busy` = state != `IDLE`. `o_owner` is the registered grant index.
- IDLE: if exactly one `mX_cyc` is high, grant X. If both are high, grant the master that is not `last_owner` (round-robin). After reset `last_owner` = 1, so master 0 wins the first tie.
- GNTx: the bus outputs are a combinational mux of master x. `wb_cyc` = `mx_cyc`; `wb_stb` = `mx_cyc & mx_stb`. `mx_ack`/`mx_err` = `wb_ack`/`wb_err` gated by `wb_cyc & wb_stb`. `mx_i_dat` = `wb_i_dat`.
- The non-owner sees `ack` = `err` = 0 and `i_dat` = 0. Its request stays pending and is never dropped.
- Release: when the owner deasserts `mx_cyc` in GNTx, go to IDLE and set `last_owner` = x. A new grant cannot occur before the following cycle, so there is always at least one cycle with `wb_cyc` = 0 between tenures.
- The tenure lasts for the whole `cyc` assertion. A 4-beat burst is never split and never preempted.
- Beat counter (2 bits) increments on each owner `ack`/`err` while in GNTx and clears on entering IDLE. It wraps 3 -> 0, which allows back-to-back bursts within one `cyc`.
- In IDLE all `wb_*` outputs are 0 and all `mX_ack`/`mX_err` are 0.
- Reset (any time, including mid-burst): state = IDLE, `last_owner` = 1, counters = 0. All outputs go to 0 immediately (asynchronously). The interrupted master must re-request.

## Timing
- Grant latency: `cyc` rising in IDLE at edge n gives the bus to that master from the cycle after edge n. The first `wb_stb` is visible one cycle after the request.
- Response path is combinational. Owner ack/err appear in the same cycle as `wb_ack`/`wb_err`.
- Simultaneous release by the owner and a new request from the other master: IDLE for one cycle, then grant the other master.
- Owner drops and immediately re-raises `cyc` while the other master is waiting: the other master wins (round-robin).

## Configuration
- `WB_ARB_TIMEOUT_EN` defined:
  - A counter runs while the owner has `wb_stb` high with no `wb_ack`/`wb_err`.
  - When it reaches `TIMEOUT`, it asserts `mx_err` for one cycle and forces `wb_stb` low in that cycle.
  - The counter clears on any `ack`/`err` and on entering IDLE.
- `WB_ARB_TIMEOUT_EN` undefined: no counter. A missing `ack` holds the bus indefinitely.

## Structure
- Shared package or config header holds the state encoding (`ARB_S_IDLE`, `ARB_S_GNT0`, `ARB_S_GNT1`, 2 bits) and reuses `WB_ADDR_W`/`RW`.
- Sub-module `wb_arb_timeout`: the timeout counter with `start`, `clear`, and `expired` signals, instantiated only under the macro.
- The remaining logic (FSM, round-robin pointer, output mux) stays in `wb_arbiter`.

## Test plan
- Reset release with only `m0_cyc`/`m0_stb` set, `adr` = 0x000800:
  - `wb_adr` = 0x000800 and `wb_cyc` = 1 on the cycle after the request.
  - One `wb_ack` with `wb_i_dat` = 0xBEEF gives `m0_ack` = 1 and `m0_i_dat` = 0xBEEF in that cycle.
  - `m1_ack` stays 0.
- Both masters request on the same cycle from reset:
  - m0 granted first and completes a 4-beat burst (4 acks) with no m1 beats interleaved.
  - One idle cycle, then m1 granted.
- m0 and m1 contend repeatedly, each releasing after one beat: grants alternate 0,1,0,1.
- `i_rst_n` pulsed low during beat 2 of an m1 burst: `wb_cyc` goes to 0 without waiting for a clock edge, and state is IDLE after release.
- With `WB_ARB_TIMEOUT_EN` and `TIMEOUT` = 8, m0 strobes and the slave never acks: `m0_err` pulses exactly 8 cycles after `stb`; the bus is released once m0 drops `cyc`.
- m0 drops `cyc` while m1 requests in the same cycle: `wb_cyc` = 0 for exactly one cycle, then `wb_adr` = `m1_adr`.
